// File: rtl/arb_mux.sv
// Registered N-channel arbitrating mux: round-robin or fixed-priority grant, one output register.
// Latency: one cycle from input transfer to out_data/out_ch/out_valid.
// Backpressure: when the output register is full and not drained, every in_ready bit drops.
module arb_mux #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RR         = 1,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready
);

    // Round-robin pointer: first index searched on the next grant.
    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       ptr_next;
    logic [CH_W-1:0]       base;
    logic                  load_en;
    logic                  grant_found;
    logic [CH_W-1:0]       grant_idx;
    logic [CH_W:0]         cand;
    logic [DATA_WIDTH-1:0] grant_data;

    // Output register can take a word when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Fixed-priority mode always searches from channel 0.
    assign base = (RR != 0) ? ptr : '0;

    // Grant search: first valid channel starting at base, wrapping modulo NUM_CH.
    // cand carries one spare bit so ptr+i never overflows before the wrap subtract.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, base} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!grant_found && in_valid[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
    end

    // Select the winning word; constant slices keep the data path free of multipliers.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_idx == CH_W'(k)) begin
                grant_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer advances past the winner; explicit wrap handles non-power-of-two NUM_CH.
    always_comb begin
        if (grant_idx == CH_W'(NUM_CH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + CH_W'(1);
        end
    end

    // One-hot accept for the winner only; gated by rst_n so it drops the moment reset asserts.
    always_comb begin
        in_ready = '0;
        if (load_en && grant_found && rst_n) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and pointer; an idle load cycle empties the register but keeps data/ch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_found) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (RR != 0) begin
                    ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Instance A: 4 channels, round-robin
    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_ch;
    logic        a_out_valid;
    logic        a_out_ready;

    // Instance B: 4 channels, fixed priority
    logic [31:0] b_data;
    logic [3:0]  b_valid;
    logic [3:0]  b_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_valid;
    logic        b_out_ready;

    // Instance C: 3 channels, round-robin
    logic [23:0] c_data;
    logic [2:0]  c_valid;
    logic [2:0]  c_ready;
    logic [7:0]  c_out_data;
    logic [1:0]  c_out_ch;
    logic        c_out_valid;
    logic        c_out_ready;

    arb_mux #(.NUM_CH(4), .DATA_WIDTH(8), .RR(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    arb_mux #(.NUM_CH(4), .DATA_WIDTH(8), .RR(0)) u_fp4 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    arb_mux #(.NUM_CH(3), .DATA_WIDTH(8), .RR(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_out_data), .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        a_valid = '0; b_valid = '0; c_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        a_valid     = 4'hF; b_valid = 4'hF; c_valid = 3'b111;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", a_out_data); end
        checks++; if (a_out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch: got %0d want 0", a_out_ch); end
        checks++; if (a_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_a: got %b want 0000", a_ready); end
        checks++; if (b_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_b: got %b want 0000", b_ready); end
        checks++; if (c_ready !== 3'b000) begin failures++; $display("FAIL reset_ready_c: got %b want 000", c_ready); end
        checks++; if (u_rr4.ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr: got %0d want 0", u_rr4.ptr); end
        a_valid = '0; b_valid = '0; c_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_channel();
        @(negedge clk);
        a_out_ready = 1'b1;
        a_data      = {8'h00, 8'hA5, 8'h00, 8'h00};
        a_valid     = 4'b0100;
        #1;
        checks++; if (a_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b want 0100", a_ready); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", a_out_valid); end
        checks++; if (a_out_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", a_out_data); end
        checks++; if (a_out_ch !== 2'd2) begin failures++; $display("FAIL single_ch: got %0d want 2", a_out_ch); end
        checks++; if (u_rr4.ptr !== 2'd3) begin failures++; $display("FAIL single_ptr: got %0d want 3", u_rr4.ptr); end
        @(negedge clk);
        a_valid = '0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 8'hA5) begin failures++; $display("FAIL idle_data_hold: got %h want a5", a_out_data); end
        checks++; if (u_rr4.ptr !== 2'd3) begin failures++; $display("FAIL idle_ptr_hold: got %0d want 3", u_rr4.ptr); end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_ch;
        logic [3:0] exp_rdy;
        do_reset();
        @(negedge clk);
        a_out_ready = 1'b1;
        a_data      = {8'h13, 8'h12, 8'h11, 8'h10};
        a_valid     = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_ch  = 2'(i % 4);
            exp_rdy = 4'b0001 << ((i + 1) % 4);
            checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d]: got %b want 1", i, a_out_valid); end
            checks++; if (a_out_ch !== exp_ch) begin failures++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, a_out_ch, exp_ch); end
            checks++; if (a_out_data !== 8'h10 + 8'(exp_ch)) begin failures++; $display("FAIL rr_data[%0d]: got %h want %h", i, a_out_data, 8'h10 + 8'(exp_ch)); end
            checks++; if (a_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d]: got %b want %b", i, a_ready, exp_rdy); end
        end
        @(negedge clk);
        a_valid = '0;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        b_out_ready = 1'b1;
        b_data      = {8'h13, 8'h12, 8'h11, 8'h10};
        b_valid     = 4'hF;
        #1;
        checks++; if (b_ready !== 4'b0001) begin failures++; $display("FAIL fp_ready_first: got %b want 0001", b_ready); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (b_out_ch !== 2'd0) begin failures++; $display("FAIL fp_ch[%0d]: got %0d want 0", i, b_out_ch); end
            checks++; if (b_out_data !== 8'h10) begin failures++; $display("FAIL fp_data[%0d]: got %h want 10", i, b_out_data); end
            checks++; if (b_ready !== 4'b0001) begin failures++; $display("FAIL fp_ready[%0d]: got %b want 0001", i, b_ready); end
        end
        checks++; if (u_fp4.ptr !== 2'd0) begin failures++; $display("FAIL fp_ptr: got %0d want 0", u_fp4.ptr); end
        @(negedge clk);
        b_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        a_out_ready = 1'b0;
        a_data      = {8'h00, 8'h00, 8'h00, 8'h3C};
        a_valid     = 4'b0001;
        @(posedge clk); #1;
        checks++; if (a_out_data !== 8'h3C || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_load: got %h/%b want 3c/1", a_out_data, a_out_valid); end
        @(negedge clk);
        a_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        a_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, a_ready); end
            @(posedge clk); #1;
            checks++; if (a_out_data !== 8'h3C || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d]: got %h/%b want 3c/1", i, a_out_data, a_out_valid); end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready: got %b want 0010", a_ready); end
        @(posedge clk); #1;
        checks++; if (a_out_data !== 8'h5A) begin failures++; $display("FAIL bp_refill_data: got %h want 5a", a_out_data); end
        checks++; if (a_out_ch !== 2'd1) begin failures++; $display("FAIL bp_refill_ch: got %0d want 1", a_out_ch); end
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_refill_valid: got %b want 1", a_out_valid); end
        @(negedge clk);
        a_valid = '0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b want 0", a_out_valid); end
    endtask

    task automatic test_np2_wrap();
        do_reset();
        @(negedge clk);
        c_out_ready = 1'b1;
        c_data      = {8'h22, 8'h21, 8'h20};
        c_valid     = 3'b010;
        @(posedge clk); #1;
        checks++; if (u_rr3.ptr !== 2'd2) begin failures++; $display("FAIL np2_ptr_setup: got %0d want 2", u_rr3.ptr); end
        @(negedge clk);
        c_valid = 3'b101;
        #1;
        checks++; if (c_ready !== 3'b100) begin failures++; $display("FAIL np2_ready_ch2: got %b want 100", c_ready); end
        @(posedge clk); #1;
        checks++; if (c_out_ch !== 2'd2 || c_out_data !== 8'h22) begin failures++; $display("FAIL np2_grant_ch2: got ch%0d/%h want ch2/22", c_out_ch, c_out_data); end
        checks++; if (u_rr3.ptr !== 2'd0) begin failures++; $display("FAIL np2_ptr_wrap: got %0d want 0", u_rr3.ptr); end
        @(negedge clk);
        c_valid = 3'b001;
        #1;
        checks++; if (c_ready !== 3'b001) begin failures++; $display("FAIL np2_ready_ch0: got %b want 001", c_ready); end
        @(posedge clk); #1;
        checks++; if (c_out_ch !== 2'd0 || c_out_data !== 8'h20) begin failures++; $display("FAIL np2_grant_ch0: got ch%0d/%h want ch0/20", c_out_ch, c_out_data); end
        checks++; if (u_rr3.ptr !== 2'd1) begin failures++; $display("FAIL np2_ptr_after: got %0d want 1", u_rr3.ptr); end
        @(negedge clk);
        c_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        a_out_ready = 1'b0;
        a_data      = {8'h77, 8'h00, 8'h00, 8'h00};
        a_valid     = 4'b1000;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h77) begin failures++; $display("FAIL mid_setup: got %b/%h want 1/77", a_out_valid, a_out_data); end
        @(negedge clk);
        a_data = {8'h78, 8'h00, 8'h00, 8'h00};
        a_out_ready = 1'b1;
        rst_n  = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h want 00", a_out_data); end
        checks++; if (a_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready: got %b want 0000", a_ready); end
        a_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        a_valid = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_out_ch !== 2'd0 || a_out_data !== 8'h10) begin failures++; $display("FAIL mid_first_grant: got ch%0d/%h want ch0/10", a_out_ch, a_out_data); end
        @(negedge clk);
        a_valid = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a_data = '0; a_valid = '0; a_out_ready = 1'b0;
        b_data = '0; b_valid = '0; b_out_ready = 1'b0;
        c_data = '0; c_valid = '0; c_out_ready = 1'b0;
        test_reset();
        test_single_channel();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_np2_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
